// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: issues loads/stores on a req/gnt/rvalid port, aligns store data, extracts load data.
// Latency: non-memory ops and misaligned accesses pass through in zero cycles; stores finish on gnt, loads on rvalid.
// Backpressure: mem_stall is held while waiting for gnt or rvalid; EX/MEM stays frozen upstream meanwhile.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   exmem_*                 EX/MEM pipeline fields (address/ALU result, rd, we, mem type/rw/width/uns, rs2)
//   fc_flush_mem_i          kill the instruction currently in MEM
//   dmem_*                  data-memory request/grant/response port
//   mem_reg_*               write-back fields to MEM/WB
//   mem_stall_o             hold EX/MEM and earlier, bubble MEM/WB
//   mem_misalign_o          1-cycle pulse on misaligned or reserved-width access
//   mem_bus_err_o           1-cycle pulse on watchdog timeout
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] exmem_op_c_i,
  input  logic [4:0]  exmem_reg_waddr_i,
  input  logic        exmem_reg_we_i,
  input  logic        exmem_mtype_i,
  input  logic        exmem_mem_rw_i,
  input  logic [1:0]  exmem_mem_width_i,
  input  logic        exmem_mem_uns_i,
  input  logic [31:0] exmem_st_data_i,
  input  logic        fc_flush_mem_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_reg_wdata_o,
  output logic [4:0]  mem_reg_waddr_o,
  output logic        mem_reg_we_o,
  output logic        mem_stall_o,
  output logic        mem_misalign_o,
  output logic        mem_bus_err_o
);

  localparam int            CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam bit            WD_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drop_q, drop_d;

  // Copy of the access fields taken while idle, so an outstanding access
  // does not depend on what flow control does to EX/MEM while we wait.
  logic [31:0] addr_q;
  logic [1:0]  width_q;
  logic        rw_q;
  logic        uns_q;
  logic        reg_we_q;
  logic [31:0] st_data_q;

  logic [31:0] cur_addr;
  logic [1:0]  cur_width;
  logic        cur_rw;
  logic [31:0] cur_st_data;
  logic        aligned;
  logic        timeout_hit;
  logic [3:0]  be_raw;
  logic [31:0] st_lanes;
  logic [31:0] rd_lane;
  logic [31:0] ld_data;

  logic        req_c;
  logic [31:0] wb_data_c;
  logic        wb_we_c;
  logic        stall_c;
  logic        misalign_c;
  logic        bus_err_c;

  // In IDLE the live EX/MEM fields describe the access; once waiting, the copy does.
  assign cur_addr    = (state_q == IDLE) ? exmem_op_c_i      : addr_q;
  assign cur_width   = (state_q == IDLE) ? exmem_mem_width_i : width_q;
  assign cur_rw      = (state_q == IDLE) ? exmem_mem_rw_i    : rw_q;
  assign cur_st_data = (state_q == IDLE) ? exmem_st_data_i   : st_data_q;

  assign timeout_hit = WD_EN && (cnt_q == TO_VAL);

  always_comb begin
    aligned  = 1'b0;
    be_raw   = 4'b1111;
    st_lanes = cur_st_data;
    case (cur_width)
      2'b00: begin
        aligned  = 1'b1;
        be_raw   = 4'b0001 << cur_addr[1:0];
        st_lanes = {4{cur_st_data[7:0]}};
      end
      2'b01: begin
        aligned  = ~cur_addr[0];
        be_raw   = 4'b0011 << cur_addr[1:0];
        st_lanes = {2{cur_st_data[15:0]}};
      end
      2'b10: begin
        aligned  = (cur_addr[1:0] == 2'b00);
      end
      default: begin
        aligned  = 1'b0;
      end
    endcase
  end

  // Load extraction always refers to the captured access.
  assign rd_lane = dmem_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_data = dmem_rdata_i;
    case (width_q)
      2'b00:   ld_data = {{24{rd_lane[7]  & ~uns_q}}, rd_lane[7:0]};
      2'b01:   ld_data = {{16{rd_lane[15] & ~uns_q}}, rd_lane[15:0]};
      default: ld_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    req_c      = 1'b0;
    wb_data_c  = '0;
    wb_we_c    = 1'b0;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    bus_err_c  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (!exmem_mtype_i) begin
          wb_data_c = exmem_op_c_i;
          wb_we_c   = exmem_reg_we_i;
        end else if (fc_flush_mem_i) begin
          // killed memory instruction: nothing issued, nothing written
        end else if (!aligned) begin
          misalign_c = 1'b1;
        end else begin
          req_c = 1'b1;
          if (dmem_gnt_i) begin
            if (!exmem_mem_rw_i) begin
              state_d = WAIT_RSP;
              stall_c = 1'b1;
            end
          end else begin
            state_d = WAIT_GNT;
            stall_c = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        if (timeout_hit) begin
          bus_err_c = 1'b1;
          state_d   = IDLE;
        end else if (fc_flush_mem_i) begin
          state_d = IDLE;
        end else begin
          req_c = 1'b1;
          if (WD_EN) cnt_d = cnt_q + CW'(1);
          if (dmem_gnt_i) begin
            if (rw_q) begin
              state_d = IDLE;
            end else begin
              state_d = WAIT_RSP;
              stall_c = 1'b1;
            end
          end else begin
            stall_c = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        // The read is already in flight; a flush only suppresses its write-back.
        if (fc_flush_mem_i) drop_d = 1'b1;
        if (timeout_hit) begin
          bus_err_c = 1'b1;
          state_d   = IDLE;
        end else if (dmem_rvalid_i) begin
          wb_data_c = ld_data;
          wb_we_c   = reg_we_q & ~drop_q & ~fc_flush_mem_i;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          if (WD_EN) cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      addr_q    <= '0;
      width_q   <= '0;
      rw_q      <= 1'b0;
      uns_q     <= 1'b0;
      reg_we_q  <= 1'b0;
      st_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      if (state_q == IDLE) begin
        addr_q    <= exmem_op_c_i;
        width_q   <= exmem_mem_width_i;
        rw_q      <= exmem_mem_rw_i;
        uns_q     <= exmem_mem_uns_i;
        reg_we_q  <= exmem_reg_we_i;
        st_data_q <= exmem_st_data_i;
      end
    end
  end

  // Outputs are forced low while reset is asserted so a request cannot
  // leak out combinationally from live EX/MEM fields during reset.
  assign dmem_req_o      = rst_n & req_c;
  assign dmem_we_o       = rst_n & req_c & cur_rw;
  assign dmem_addr_o     = (rst_n && req_c) ? {cur_addr[31:2], 2'b00} : '0;
  assign dmem_be_o       = (rst_n && req_c) ? be_raw : '0;
  assign dmem_wdata_o    = (rst_n && req_c && cur_rw) ? st_lanes : '0;
  assign mem_reg_wdata_o = rst_n ? wb_data_c : '0;
  assign mem_reg_waddr_o = rst_n ? exmem_reg_waddr_i : '0;
  assign mem_reg_we_o    = rst_n & wb_we_c;
  assign mem_stall_o     = rst_n & stall_c;
  assign mem_misalign_o  = rst_n & misalign_c;
  assign mem_bus_err_o   = rst_n & bus_err_c;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed cases plus randomized transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] exmem_op_c;
  logic [4:0]  exmem_reg_waddr;
  logic        exmem_reg_we;
  logic        exmem_mtype;
  logic        exmem_mem_rw;
  logic [1:0]  exmem_mem_width;
  logic        exmem_mem_uns;
  logic [31:0] exmem_st_data;
  logic        fc_flush_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_reg_wdata;
  logic [4:0]  mem_reg_waddr;
  logic        mem_reg_we;
  logic        mem_stall;
  logic        mem_misalign;
  logic        mem_bus_err;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .exmem_op_c_i      (exmem_op_c),
    .exmem_reg_waddr_i (exmem_reg_waddr),
    .exmem_reg_we_i    (exmem_reg_we),
    .exmem_mtype_i     (exmem_mtype),
    .exmem_mem_rw_i    (exmem_mem_rw),
    .exmem_mem_width_i (exmem_mem_width),
    .exmem_mem_uns_i   (exmem_mem_uns),
    .exmem_st_data_i   (exmem_st_data),
    .fc_flush_mem_i    (fc_flush_mem),
    .dmem_req_o        (dmem_req),
    .dmem_we_o         (dmem_we),
    .dmem_addr_o       (dmem_addr),
    .dmem_be_o         (dmem_be),
    .dmem_wdata_o      (dmem_wdata),
    .dmem_gnt_i        (dmem_gnt),
    .dmem_rvalid_i     (dmem_rvalid),
    .dmem_rdata_i      (dmem_rdata),
    .mem_reg_wdata_o   (mem_reg_wdata),
    .mem_reg_waddr_o   (mem_reg_waddr),
    .mem_reg_we_o      (mem_reg_we),
    .mem_stall_o       (mem_stall),
    .mem_misalign_o    (mem_misalign),
    .mem_bus_err_o     (mem_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, want finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (spec arithmetic) ----------------
  function automatic bit mis_ref(input logic [31:0] a, input logic [1:0] w);
    int off;
    off = int'(a) & 3;
    case (w)
      2'd0:    return 1'b0;
      2'd1:    return (off % 2) != 0;
      2'd2:    return off != 0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_ref(input logic [31:0] a, input logic [1:0] w);
    int b;
    int off;
    off = int'(a) & 3;
    case (w)
      2'd0:    b = 1 << off;
      2'd1:    b = 3 << off;
      default: b = 15;
    endcase
    return b[3:0];
  endfunction

  function automatic logic [31:0] wd_ref(input logic [31:0] d, input logic [1:0] w);
    longint v;
    case (w)
      2'd0:    v = (longint'(d) % 256) * 64'h01010101;
      2'd1:    v = (longint'(d) % 65536) * 64'h00010001;
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] ld_ref(input logic [31:0] a, input logic [1:0] w,
                                         input logic u, input logic [31:0] d);
    longint v;
    longint full;
    int     off;
    off  = int'(a) & 3;
    full = 0;
    full[31:0] = d;
    v = full / (longint'(1) << (8 * off));
    case (w)
      2'd0: begin
        v = v % 256;
        if (!u && v >= 128) v = v - 256;
      end
      2'd1: begin
        v = v % 65536;
        if (!u && v >= 32768) v = v - 65536;
      end
      default: v = full;
    endcase
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    exmem_mtype     = 1'b0;
    exmem_mem_rw    = 1'b0;
    exmem_mem_width = 2'd0;
    exmem_mem_uns   = 1'b0;
    exmem_reg_we    = 1'b0;
    exmem_reg_waddr = 5'd0;
    exmem_op_c      = $urandom;
    exmem_st_data   = $urandom;
    fc_flush_mem    = 1'b0;
    dmem_gnt        = 1'b0;
    dmem_rvalid     = 1'b0;
    dmem_rdata      = $urandom;
  endtask

  task automatic set_instr(input logic rw, input logic [1:0] w, input logic u,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic rwe, input logic [4:0] rd);
    exmem_mtype     = 1'b1;
    exmem_mem_rw    = rw;
    exmem_mem_width = w;
    exmem_mem_uns   = u;
    exmem_op_c      = a;
    exmem_st_data   = sd;
    exmem_reg_we    = rwe;
    exmem_reg_waddr = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One memory instruction. gd = cycles until gnt, rd = cycles from gnt to
  // rvalid (loads), fk = cycle index carrying a flush (-1 for none).
  task automatic txn(input string tag, input logic [31:0] a, input logic [1:0] w,
                     input logic rw, input logic u, input logic [31:0] sd,
                     input logic [31:0] rdat, input logic rwe,
                     input int gd, input int rd, input int fk);
    int          e_raw;
    int          e_end;
    bit          tmo;
    bit          flushed;
    bit          e_req;
    bit          e_we;
    logic [4:0]  dst;
    dst = 5'($urandom_range(1, 31));
    set_instr(rw, w, u, a, sd, rwe, dst);
    fc_flush_mem = 1'b0;
    dmem_gnt     = 1'b0;
    dmem_rvalid  = 1'b0;
    if (mis_ref(a, w)) begin
      #3;
      chk({tag, ".mis"},      {31'b0, mem_misalign}, 32'd1);
      chk({tag, ".mis_req"},  {31'b0, dmem_req},     32'd0);
      chk({tag, ".mis_we"},   {31'b0, mem_reg_we},   32'd0);
      chk({tag, ".mis_stl"},  {31'b0, mem_stall},    32'd0);
      next_cycle();
      set_idle();
      return;
    end
    e_raw   = rw ? gd : gd + rd;
    tmo     = e_raw > TO;
    e_end   = tmo ? TO + 1 : e_raw;
    flushed = !rw && fk > gd && fk <= e_end;
    for (int k = 0; k <= e_end; k++) begin
      if (k > 0) next_cycle();
      dmem_gnt     = (k == gd) && !(tmo && k == e_end);
      dmem_rvalid  = !rw && !tmo && (k == e_raw);
      dmem_rdata   = (k == e_raw) ? rdat : $urandom;
      fc_flush_mem = (k == fk);
      #3;
      e_req = (k <= gd) && !(tmo && k == e_end);
      e_we  = (k == e_end) && !tmo && !rw && rwe && !flushed;
      chk({tag, ".req"},   {31'b0, dmem_req},     {31'b0, e_req});
      chk({tag, ".stall"}, {31'b0, mem_stall},    {31'b0, (k < e_end)});
      chk({tag, ".berr"},  {31'b0, mem_bus_err},  {31'b0, (tmo && k == e_end)});
      chk({tag, ".we"},    {31'b0, mem_reg_we},   {31'b0, e_we});
      chk({tag, ".mis0"},  {31'b0, mem_misalign}, 32'd0);
      chk({tag, ".waddr"}, {27'b0, mem_reg_waddr}, {27'b0, dst});
      if (e_req) begin
        chk({tag, ".addr"},  dmem_addr, {a[31:2], 2'b00});
        chk({tag, ".be"},    {28'b0, dmem_be}, {28'b0, be_ref(a, w)});
        chk({tag, ".bwe"},   {31'b0, dmem_we}, {31'b0, rw});
        if (rw) chk({tag, ".bwdata"}, dmem_wdata, wd_ref(sd, w));
      end
      if (e_we) chk({tag, ".wdata"}, mem_reg_wdata, ld_ref(a, w, u, rdat));
    end
    next_cycle();
    set_idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    set_idle();
    // live load with gnt while in reset: everything must stay low
    set_instr(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b1, 5'd3);
    dmem_gnt = 1'b1;
    #3;
    chk("rst.req",   {31'b0, dmem_req},    32'd0);
    chk("rst.stall", {31'b0, mem_stall},   32'd0);
    chk("rst.we",    {31'b0, mem_reg_we},  32'd0);
    chk("rst.wdata", mem_reg_wdata,        32'd0);
    chk("rst.berr",  {31'b0, mem_bus_err}, 32'd0);
    set_idle();
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // non-memory passthrough
    exmem_op_c   = 32'h1234_5678;
    exmem_reg_we = 1'b1;
    exmem_reg_waddr = 5'd9;
    #3;
    chk("alu.wdata", mem_reg_wdata, 32'h1234_5678);
    chk("alu.we",    {31'b0, mem_reg_we}, 32'd1);
    chk("alu.stall", {31'b0, mem_stall},  32'd0);
    chk("alu.req",   {31'b0, dmem_req},   32'd0);
    next_cycle();
    set_idle();

    txn("lw",   32'h100, 2'd2, 1'b0, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b1, 0, 3, -1);
    txn("lb",   32'h103, 2'd0, 1'b0, 1'b0, 32'h0,        32'h8012_3456, 1'b1, 0, 1, -1);
    txn("lbu",  32'h103, 2'd0, 1'b0, 1'b1, 32'h0,        32'h8012_3456, 1'b1, 1, 2, -1);
    txn("lh",   32'h102, 2'd1, 1'b0, 1'b0, 32'h0,        32'h8001_1234, 1'b1, 0, 1, -1);
    txn("sb",   32'h101, 2'd0, 1'b1, 1'b0, 32'h0000_00AB, 32'h0,        1'b1, 2, 0, -1);
    txn("sh",   32'h102, 2'd1, 1'b1, 1'b0, 32'h1111_C0DE, 32'h0,        1'b1, 0, 0, -1);
    txn("lwmis",32'h102, 2'd2, 1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 0, 1, -1);
    txn("w11",  32'h100, 2'd3, 1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 0, 1, -1);
    txn("lwfl", 32'h200, 2'd2, 1'b0, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b1, 0, 3, 1);
    txn("tmo",  32'h300, 2'd2, 1'b0, 1'b0, 32'h0,        32'h0,         1'b1, 99, 1, -1);

    // late rvalid after the timeout must be ignored in IDLE
    exmem_op_c   = 32'h0BAD_0000;
    exmem_reg_we = 1'b1;
    dmem_rvalid  = 1'b1;
    dmem_rdata   = 32'h5555_5555;
    #3;
    chk("late.wdata", mem_reg_wdata, 32'h0BAD_0000);
    chk("late.stall", {31'b0, mem_stall},   32'd0);
    chk("late.berr",  {31'b0, mem_bus_err}, 32'd0);
    next_cycle();
    set_idle();

    // flush while waiting for gnt drops the request
    set_instr(1'b1, 2'd2, 1'b0, 32'h400, 32'h77, 1'b0, 5'd0);
    #3;
    chk("fgnt.req0",   {31'b0, dmem_req},  32'd1);
    chk("fgnt.stall0", {31'b0, mem_stall}, 32'd1);
    next_cycle();
    fc_flush_mem = 1'b1;
    #3;
    chk("fgnt.req1",   {31'b0, dmem_req},   32'd0);
    chk("fgnt.stall1", {31'b0, mem_stall},  32'd0);
    chk("fgnt.we1",    {31'b0, mem_reg_we}, 32'd0);
    next_cycle();
    set_idle();
    exmem_op_c   = 32'h0000_0042;
    exmem_reg_we = 1'b1;
    #3;
    chk("fgnt.idle", mem_reg_wdata, 32'h0000_0042);
    next_cycle();
    set_idle();

    // reset asserted while waiting for a response
    set_instr(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 1'b1, 5'd4);
    dmem_gnt = 1'b1;
    next_cycle();
    dmem_gnt = 1'b0;
    #3;
    chk("rrsp.stall", {31'b0, mem_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rrsp.req",    {31'b0, dmem_req},  32'd0);
    chk("rrsp.stall0", {31'b0, mem_stall}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_idle();
    exmem_op_c   = 32'h0000_0099;
    exmem_reg_we = 1'b1;
    dmem_rvalid  = 1'b1;
    #3;
    chk("rrsp.drop", mem_reg_wdata, 32'h0000_0099);
    chk("rrsp.st",   {31'b0, mem_stall}, 32'd0);
    next_cycle();
    set_idle();

    // randomized transactions
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  w;
      logic        rw;
      int          gd;
      int          rd;
      int          fk;
      a  = $urandom;
      w  = 2'($urandom_range(0, 3));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd1) a[0] = 1'b0;
        if (w == 2'd2) a[1:0] = 2'b00;
      end
      gd = $urandom_range(0, 5);
      rd = $urandom_range(1, 4);
      fk = -1;
      if (!rw && $urandom_range(0, 3) == 0) fk = gd + 1 + $urandom_range(0, rd - 1);
      txn("rnd", a, w, rw, 1'($urandom_range(0, 1)), $urandom, $urandom,
          1'($urandom_range(0, 1)), gd, rd, fk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
